// File: rtl/riscv_mini_pkg.sv
// Shared types and constants for the load/store unit.
//   mem_size_e  : access size as stored inside the unit (reserved size folds to word)
//   lsu_state_e : load/store FSM states, also exported on the debug port
//   L_OP / S_OP : value of the latched write-enable for loads and stores
//   decode_size : maps the raw 2-bit size field onto mem_size_e
package riscv_mini_pkg;

    typedef enum logic [1:0] {
        MEM_B = 2'b00,
        MEM_H = 2'b01,
        MEM_W = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } lsu_state_e;

    localparam logic L_OP = 1'b0;
    localparam logic S_OP = 1'b1;

    // Size encoding 2'b11 is reserved and behaves exactly like a word access.
    function automatic mem_size_e decode_size(input logic [1:0] size);
        mem_size_e result;
        case (size)
            2'b00:   result = MEM_B;
            2'b01:   result = MEM_H;
            default: result = MEM_W;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// load_align: combinational load-data alignment.
// Shifts the bus word right so the addressed byte/half lands in bit 0, then
// sign- or zero-extends from bit 7 (byte) or bit 15 (half). Words pass through.
// Ports:
//   rdata       in  XLEN  raw word from the data bus
//   offset      in  2     byte offset within the word (addr[1:0])
//   size        in  enum  access size
//   is_unsigned in  1     1 = zero-extend, 0 = sign-extend
//   result      out XLEN  aligned, extended value
module load_align
    import riscv_mini_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  mem_size_e       size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;
    logic            sign;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        sign    = 1'b0;
        result  = shifted;
        case (size)
            MEM_B: begin
                sign   = ~is_unsigned & shifted[7];
                result = {{(XLEN-8){sign}}, shifted[7:0]};
            end
            MEM_H: begin
                sign   = ~is_unsigned & shifted[15];
                result = {{(XLEN-16){sign}}, shifted[15:0]};
            end
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage running one load or store per instruction.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   mem_read_i, mem_write_i      request from control (write wins if both)
//   size_i, unsigned_i           access size and load extension mode
//   addr_i, wdata_i              byte address, right-justified store data
//   stall_o                      hold upstream while an access is in flight
//   rdata_o, rdata_valid_o       load result and its one-cycle valid pulse
//   misalign_o, bus_err_o        one-cycle error pulses
//   dmem_*                       data-memory bus (req/gnt/rvalid)
//   state_dbg_o                  current FSM state, for observation only
//
// Bus handshake: dmem_req_o rises on entering REQ and stays high, with
// address/we/be/wdata stable, until the cycle dmem_gnt_i is sampled high.
// For loads the data arrives later as a single-cycle dmem_rvalid_i pulse in
// WAIT. gnt and rvalid seen in any other state are ignored.
//
// TIMEOUT bounds the number of cycles spent in REQ+WAIT; it must be 2..255
// because the counter is 8 bits wide.
module load_store_unit
    import riscv_mini_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            mem_read_i,
    input  logic            mem_write_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic            stall_o,
    output logic [XLEN-1:0] rdata_o,
    output logic            rdata_valid_o,
    output logic            misalign_o,
    output logic            bus_err_o,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_gnt_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output lsu_state_e      state_dbg_o
);

    lsu_state_e      state;
    logic [7:0]      cnt;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] wdata_q;
    mem_size_e       size_q;
    logic            uns_q;
    logic            req_q;
    logic [XLEN-1:0] rdata_q;
    logic            rdata_valid_q;
    logic            bus_err_q;

    logic            request;
    mem_size_e       size_n;
    logic            misaligned;
    logic            start;
    logic [3:0]      be_n;
    logic [XLEN-1:0] wdata_n;
    logic [XLEN-1:0] load_result;
    logic            timeout_hit;

    // Decode of the upstream request; only meaningful while IDLE.
    always_comb begin
        request = mem_read_i | mem_write_i;
        size_n  = decode_size(size_i);
        misaligned = 1'b0;
        be_n       = 4'b1111;
        wdata_n    = wdata_i;
        case (size_n)
            MEM_B: begin
                be_n    = 4'b0001 << addr_i[1:0];
                wdata_n = {(XLEN/8){wdata_i[7:0]}};
            end
            MEM_H: begin
                misaligned = addr_i[0];
                be_n       = 4'b0011 << {addr_i[1], 1'b0};
                wdata_n    = {(XLEN/16){wdata_i[15:0]}};
            end
            default: begin
                misaligned = (addr_i[1:0] != 2'b00);
            end
        endcase
        start = (state == IDLE) & request & ~misaligned;
    end

    // The counter holds the number of REQ/WAIT cycles already completed, so
    // the cycle in which it equals TIMEOUT-1 is the last one allowed.
    assign timeout_hit = (cnt == 8'(TIMEOUT - 1));

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata      (dmem_rdata_i),
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .is_unsigned(uns_q),
        .result     (load_result)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= IDLE;
            cnt           <= 8'd0;
            addr_q        <= '0;
            we_q          <= L_OP;
            be_q          <= 4'b0000;
            wdata_q       <= '0;
            size_q        <= MEM_B;
            uns_q         <= 1'b0;
            req_q         <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            // Result/error flags are single-cycle pulses aligned with DONE.
            rdata_valid_q <= 1'b0;
            bus_err_q     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= addr_i;
                        we_q    <= mem_write_i ? S_OP : L_OP;
                        be_q    <= be_n;
                        wdata_q <= wdata_n;
                        size_q  <= size_n;
                        uns_q   <= unsigned_i;
                        cnt     <= 8'd0;
                        req_q   <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    cnt <= cnt + 8'd1;
                    if (dmem_gnt_i) begin
                        req_q <= 1'b0;
                        state <= (we_q == S_OP) ? DONE : WAIT;
                    end else if (timeout_hit) begin
                        req_q     <= 1'b0;
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (dmem_rvalid_i) begin
                        rdata_q       <= load_result;
                        rdata_valid_q <= 1'b1;
                        state         <= DONE;
                    end else if (timeout_hit) begin
                        rdata_q   <= '0;
                        bus_err_q <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // stall rises in the accepting IDLE cycle so upstream holds its operands,
    // and drops in DONE so the pipeline advances as the result is presented.
    assign stall_o       = start | (state == REQ) | (state == WAIT);
    assign misalign_o    = (state == IDLE) & request & misaligned;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign bus_err_o     = bus_err_q;
    assign dmem_req_o    = req_q;
    assign dmem_we_o     = we_q;
    assign dmem_addr_o   = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_be_o     = be_q;
    assign dmem_wdata_o  = wdata_q;
    assign state_dbg_o   = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed cases followed by random loads and
// stores, with a bus responder, a reference model and a scoreboard monitor.
module tb_load_store_unit;
    import riscv_mini_pkg::*;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            mem_read_i, mem_write_i, unsigned_i;
    logic [1:0]      size_i;
    logic [XLEN-1:0] addr_i, wdata_i;
    logic            stall_o, rdata_valid_o, misalign_o, bus_err_o;
    logic [XLEN-1:0] rdata_o;
    logic            dmem_req_o, dmem_we_o;
    logic [XLEN-1:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]      dmem_be_o;
    logic            dmem_gnt_i, dmem_rvalid_i;
    logic [XLEN-1:0] dmem_rdata_i;
    lsu_state_e      state_dbg_o;

    // ---------------- clock / reset ----------------
    always #5 clk_i = ~clk_i;

    load_store_unit #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .size_i(size_i), .unsigned_i(unsigned_i),
        .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i),
        .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .state_dbg_o(state_dbg_o)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int          gnt_dly;
        int          rv_dly;
        logic        is_load;
        logic [31:0] rdata;
    } resp_cfg_t;

    resp_cfg_t   cfg_q[$];
    logic [68:0] bus_exp_q[$];   // {we, be, word address, store data (0 for loads)}
    logic [33:0] rsp_exp_q[$];   // {kind, data}: 1 = load data, 2 = misalign, 3 = bus error

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int norm_size(input logic [1:0] size);
        return (size == 2'd3) ? 2 : int'(size);
    endfunction

    function automatic logic is_aligned(input logic [1:0] size, input logic [31:0] addr);
        int sz = norm_size(size);
        return (addr % (1 << sz)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] addr);
        int sz  = norm_size(size);
        int off = int'(addr % 4);
        if (sz == 0) return 4'(1 << off);
        if (sz == 1) return 4'(3 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] w);
        int sz = norm_size(size);
        if (sz == 0) return (w & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr, input logic [31:0] rdata);
        int sz = norm_size(size);
        logic [31:0] v;
        v = rdata >> (8 * (addr % 4));
        if (sz == 0) begin
            v = v & 32'hFF;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 1) begin
            v = v & 32'hFFFF;
            if (!uns && v >= 32768) v = v - 65536;
        end
        return v;
    endfunction

    // ---------------- bus responder ----------------
    initial begin
        resp_cfg_t c;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        forever begin
            @(posedge clk_i); #1;
            if (dmem_req_o) begin
                if (cfg_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_req: dmem_req_o=1 with no access pending (t=%0t)", $time);
                    c.gnt_dly = 0; c.rv_dly = 0; c.is_load = 1'b0; c.rdata = '0;
                end else begin
                    c = cfg_q.pop_front();
                end
                for (int i = 0; i < c.gnt_dly; i++) begin @(posedge clk_i); #1; end
                dmem_gnt_i = 1'b1;
                @(posedge clk_i); #1;
                dmem_gnt_i = 1'b0;
                if (c.is_load) begin
                    for (int i = 0; i < c.rv_dly; i++) begin @(posedge clk_i); #1; end
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = c.rdata;
                    @(posedge clk_i); #1;
                    dmem_rvalid_i = 1'b0;
                    dmem_rdata_i  = $urandom;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic [1:0]  kind;
        logic [31:0] data;
        forever begin
            @(negedge clk_i);
            if (dmem_req_o && dmem_gnt_i) begin
                if (bus_exp_q.size() == 0)
                    check("bus_txn_unexpected", 128'(bus_exp_q.size()), 128'(1));
                else
                    check("bus_txn", {dmem_we_o, dmem_be_o, dmem_addr_o,
                                      (dmem_we_o ? dmem_wdata_o : 32'h0)}, bus_exp_q.pop_front());
            end
            if (rdata_valid_o || misalign_o || bus_err_o) begin
                check("single_pulse", $countones({rdata_valid_o, misalign_o, bus_err_o}), 1);
                kind = rdata_valid_o ? 2'd1 : (misalign_o ? 2'd2 : 2'd3);
                data = (kind == 2'd2) ? 32'h0 : rdata_o;
                if (rsp_exp_q.size() == 0)
                    check("response_unexpected", {kind, data}, 34'h0);
                else
                    check("response", {kind, data}, rsp_exp_q.pop_front());
            end
        end
    end

    // ---------------- driver ----------------
    task automatic idle_inputs();
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        size_i      = 2'b00;
        unsigned_i  = 1'b0;
        addr_i      = '0;
        wdata_i     = '0;
    endtask

    // Called just after a rising edge. Pushes expectations, presents the
    // request, holds it while stall_o is high, and checks the stall length.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        resp_cfg_t c;
        logic      is_store = wr;
        int        exp_stall;
        int        n;
        int        total;
        if (!is_aligned(size, addr)) begin
            rsp_exp_q.push_back({2'd2, 32'h0});
            exp_stall = 0;
        end else begin
            c.gnt_dly = gnt_dly; c.rv_dly = rv_dly; c.is_load = !is_store; c.rdata = rdata;
            cfg_q.push_back(c);
            bus_exp_q.push_back({is_store, model_be(size, addr), addr & 32'hFFFF_FFFC,
                                 (is_store ? model_wdata(size, wdata) : 32'h0)});
            if (is_store) begin
                exp_stall = 1 + (gnt_dly + 1);
            end else begin
                total = (gnt_dly + 1) + (rv_dly + 1);
                if (total > TIMEOUT) begin
                    rsp_exp_q.push_back({2'd3, 32'h0});
                    exp_stall = 1 + TIMEOUT;
                end else begin
                    rsp_exp_q.push_back({2'd1, model_load(size, uns, addr, rdata)});
                    exp_stall = 1 + total;
                end
            end
        end
        mem_read_i = rd; mem_write_i = wr; size_i = size; unsigned_i = uns;
        addr_i = addr; wdata_i = wdata;
        n = 0;
        forever begin
            @(negedge clk_i);
            if (!stall_o) break;
            n++;
            if (n > 300) break;
        end
        check("stall_cycles", n, exp_stall);
        @(posedge clk_i); #1;
        idle_inputs();
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin @(posedge clk_i); #1; end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0]  sz;
        logic [31:0] a;
        logic        rd, wr;
        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Reset state: everything quiet, FSM in IDLE.
        check("reset_outputs", {stall_o, rdata_o, rdata_valid_o, misalign_o, bus_err_o,
                                dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, 106'h0);
        check("reset_state", state_dbg_o, IDLE);

        // LW 0x100, zero-wait bus.
        issue(1, 0, 2'b10, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
        // LB / LBU 0x103 from 0x80FFFFFF.
        issue(1, 0, 2'b00, 0, 32'h103, 32'h0, 32'h80FFFFFF, 0, 0);
        issue(1, 0, 2'b00, 1, 32'h103, 32'h0, 32'h80FFFFFF, 1, 2);
        // SH 0x102 with grant held off three cycles.
        issue(0, 1, 2'b01, 0, 32'h102, 32'h1234ABCD, 32'h0, 3, 0);
        // Misaligned LW is rejected without a bus access.
        issue(1, 0, 2'b10, 0, 32'h101, 32'h0, 32'h0, 0, 0);
        idle_cycles(2);
        // Both read and write: store wins. Reserved size behaves as a word.
        issue(1, 1, 2'b11, 0, 32'h40, 32'hCAFEF00D, 32'h0, 0, 0);
        issue(1, 0, 2'b11, 0, 32'h44, 32'h0, 32'h89ABCDEF, 0, 1);
        // LH signed / LHU from the upper half.
        issue(1, 0, 2'b01, 0, 32'h202, 32'h0, 32'h8001_7FFF, 0, 0);
        issue(1, 0, 2'b01, 1, 32'h202, 32'h0, 32'h8001_7FFF, 0, 0);

        // Timeout: grant but data arrives only after the unit has given up.
        issue(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h12345678, 0, TIMEOUT + 3);
        idle_cycles(10);
        check("timeout_back_idle", state_dbg_o, IDLE);

        // Reset while waiting for load data; the late rvalid must be ignored.
        cfg_q.push_back('{gnt_dly: 0, rv_dly: 5, is_load: 1'b1, rdata: 32'h55AA55AA});
        bus_exp_q.push_back({1'b0, 4'hF, 32'h400, 32'h0});
        mem_read_i = 1'b1; size_i = 2'b10; addr_i = 32'h400;
        idle_cycles(2);
        check("reset_test_in_wait", state_dbg_o, WAIT);
        rst_i = 1'b1;
        idle_inputs();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        check("midreset_outputs", {stall_o, rdata_o, rdata_valid_o, misalign_o, bus_err_o,
                                   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o}, 106'h0);
        check("midreset_state", state_dbg_o, IDLE);
        idle_cycles(12);

        // Random loads and stores.
        for (int k = 0; k < 80; k++) begin
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                else if (sz != 2'b00) a[1:0] = 2'b00;
            end
            issue(rd, wr, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
            idle_cycles($urandom_range(0, 2));
        end

        idle_cycles(8);
        check("bus_queue_drained", bus_exp_q.size(), 0);
        check("rsp_queue_drained", rsp_exp_q.size(), 0);
        check("cfg_queue_drained", cfg_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
